// File: rtl/lut_settle_eval.sv
// lut_settle_eval: programmable N_IN-input lookup gate with input settling.
// The output is re-evaluated only after the inputs have been stable for SETTLE
// cycles. The truth table can be replaced at run time by shifting in W bits;
// the first bit shifted in becomes row 0.
module lut_settle_eval #(
   parameter int                    N_IN    = 3,
   parameter int                    SETTLE  = 4,
   parameter logic [(2**N_IN)-1:0]  INIT_TT = 8'h4E
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_IN-1:0] in,
   input  logic            cfg_en,
   input  logic            cfg_bit,
   output logic            cfg_done,
   output logic            out,
   output logic            out_valid,
   output logic            changed
);

   localparam int W     = 2**N_IN;
   localparam int CNT_W = $clog2(SETTLE + 1);
   localparam int CFG_W = ($clog2(W) > 1) ? $clog2(W) : 1;

   localparam logic [CNT_W-1:0] SETTLE_MAX  = CNT_W'(SETTLE);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
   localparam logic [CFG_W-1:0] CFG_LAST    = CFG_W'(W - 1);

   logic [W-1:0]     tt;
   logic [W-1:0]     shadow;
   logic [W-1:0]     shadow_next;
   logic [N_IN-1:0]  in_q;
   logic [N_IN-1:0]  tt_idx;
   logic [CNT_W-1:0] cnt;
   logic [CFG_W-1:0] cfg_cnt;
   logic             in_moved;
   logic             commit;
   logic             eval_now;
   logic             eval_val;

   // A commit and an input change both restart settling; either one
   // suppresses an evaluation that would otherwise land on the same edge.
   assign in_moved    = (in != in_q);
   assign commit      = cfg_en && (cfg_cnt == CFG_LAST);
   assign eval_now    = !in_moved && !commit && (cnt == SETTLE_LAST);
   assign shadow_next = {shadow[W-2:0], cfg_bit};

   // Row 0 lives in the table MSB, so the bit index is W-1-r, which for an
   // N_IN-bit row number is simply its bitwise complement.
   assign tt_idx   = ~in_q;
   assign eval_val = tt[tt_idx];

   // Track the previous input and count how long it has stayed unchanged,
   // saturating at SETTLE so only one evaluation happens per stable period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_q <= '0;
         cnt  <= '0;
      end else begin
         in_q <= in;
         if (in_moved || commit) begin
            cnt <= '0;
         end else if (cnt < SETTLE_MAX) begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   // Register the function value once the input has settled; out holds its
   // last evaluated value whenever out_valid is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out       <= 1'b0;
         out_valid <= 1'b0;
         changed   <= 1'b0;
      end else begin
         changed <= eval_now && (eval_val != out);
         if (in_moved || commit) begin
            out_valid <= 1'b0;
         end else if (eval_now) begin
            out       <= eval_val;
            out_valid <= 1'b1;
         end
      end
   end

   // Serial table loader: shift bits into a shadow register and commit the
   // whole table on the W-th bit; dropping cfg_en early abandons the load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tt       <= INIT_TT;
         shadow   <= '0;
         cfg_cnt  <= '0;
         cfg_done <= 1'b0;
      end else begin
         cfg_done <= commit;
         if (cfg_en) begin
            shadow <= shadow_next;
            if (commit) begin
               tt      <= shadow_next;
               cfg_cnt <= '0;
            end else begin
               cfg_cnt <= cfg_cnt + CFG_W'(1);
            end
         end else begin
            cfg_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_lut_settle_eval.sv
// tb_lut_settle_eval: drives two lut_settle_eval instances (3-input default
// table and 2-input XOR table). Expected outputs are pushed to a scoreboard
// queue as stimulus is applied and popped after each clock edge; directed
// checks on the key scenarios use hand-derived constants.
module tb_lut_settle_eval;

   localparam int SETTLE = 4;

   typedef struct {
      logic [63:0] tt;
      logic [63:0] shadow;
      logic [5:0]  in_q;
      int          cnt;
      int          cfg_cnt;
      logic        out;
      logic        valid;
      logic        chg;
      logic        done;
   } model_t;

   typedef struct {
      int   dut;
      logic out;
      logic valid;
      logic chg;
      logic done;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n_a, rst_n_b;
   logic [2:0] a_in;
   logic       a_en, a_bit;
   logic       a_done, a_out, a_valid, a_chg;
   logic [1:0] b_in;
   logic       b_en, b_bit;
   logic       b_done, b_out, b_valid, b_chg;

   exp_t   sb_q[$];
   exp_t   mon_e;
   model_t mdl_a, mdl_b;
   int     n_checks = 0;
   int     n_fail   = 0;

   // Free-running clock
   always #5 clk = ~clk;

   lut_settle_eval #(.N_IN(3), .SETTLE(SETTLE), .INIT_TT(8'h4E)) dut_a (
      .clk(clk), .rst_n(rst_n_a), .in(a_in), .cfg_en(a_en), .cfg_bit(a_bit),
      .cfg_done(a_done), .out(a_out), .out_valid(a_valid), .changed(a_chg)
   );

   lut_settle_eval #(.N_IN(2), .SETTLE(SETTLE), .INIT_TT(4'h6)) dut_b (
      .clk(clk), .rst_n(rst_n_b), .in(b_in), .cfg_en(b_en), .cfg_bit(b_bit),
      .cfg_done(b_done), .out(b_out), .out_valid(b_valid), .changed(b_chg)
   );

   task automatic checkOutput(input string tag, input logic obs, input logic exp_val);
      n_checks++;
      if (obs !== exp_val) begin
         n_fail++;
         $display("[TB] FAIL %s: got %b, expected %b at %0t", tag, obs, exp_val, $time);
      end
   endtask

   function automatic model_t model_reset(input logic [63:0] init);
      model_t m;
      m.tt = init; m.shadow = '0; m.in_q = '0; m.cnt = 0; m.cfg_cnt = 0;
      m.out = 1'b0; m.valid = 1'b0; m.chg = 1'b0; m.done = 1'b0;
      return m;
   endfunction

   // One clock edge of the behavioural reference
   function automatic model_t model_step(input model_t m, input int n, input logic [5:0] in_v,
                                         input logic en, input logic b);
      model_t      nx;
      int          w;
      logic        commit, moved, val;
      logic [63:0] mask;
      nx     = m;
      w      = 1 << n;
      mask   = (64'd1 << w) - 64'd1;
      commit = en && (m.cfg_cnt == w - 1);
      moved  = (in_v != m.in_q);
      nx.in_q = in_v;
      nx.chg  = 1'b0;
      nx.done = 1'b0;
      if (moved || commit) begin
         nx.cnt   = 0;
         nx.valid = 1'b0;
      end else if (m.cnt < SETTLE) begin
         nx.cnt = m.cnt + 1;
         if (m.cnt == SETTLE - 1) begin
            val      = m.tt[w - 1 - int'(m.in_q)];
            nx.chg   = (val != m.out);
            nx.out   = val;
            nx.valid = 1'b1;
         end
      end
      if (en) begin
         nx.shadow = ((m.shadow << 1) | {63'd0, b}) & mask;
         if (commit) begin
            nx.tt      = nx.shadow;
            nx.cfg_cnt = 0;
            nx.done    = 1'b1;
         end else begin
            nx.cfg_cnt = m.cfg_cnt + 1;
         end
      end else begin
         nx.cfg_cnt = 0;
      end
      return nx;
   endfunction

   // Drive one cycle of inputs on both DUTs and queue the expected results
   task automatic applyStimulus(input logic [2:0] in_a, input logic en_a, input logic bit_a,
                                input logic [1:0] in_b, input logic en_b, input logic bit_b);
      @(negedge clk);
      a_in = in_a; a_en = en_a; a_bit = bit_a;
      b_in = in_b; b_en = en_b; b_bit = bit_b;
      mdl_a = model_step(mdl_a, 3, {3'b000, in_a}, en_a, bit_a);
      mdl_b = model_step(mdl_b, 2, {4'b0000, in_b}, en_b, bit_b);
      sb_q.push_back('{dut: 0, out: mdl_a.out, valid: mdl_a.valid, chg: mdl_a.chg, done: mdl_a.done});
      sb_q.push_back('{dut: 1, out: mdl_b.out, valid: mdl_b.valid, chg: mdl_b.chg, done: mdl_b.done});
      @(posedge clk);
      #2;
   endtask

   task automatic stepA(input logic [2:0] i, input logic e, input logic b);
      applyStimulus(i, e, b, b_in, 1'b0, 1'b0);
   endtask

   task automatic stepB(input logic [1:0] i, input logic e, input logic b);
      applyStimulus(a_in, 1'b0, 1'b0, i, e, b);
   endtask

   // Asynchronous reset pulse between clock edges, checking the reset state
   task automatic pulseReset(input int which);
      if (which == 0) begin
         rst_n_a = 1'b0;
         #2;
         checkOutput("rst_a_out", a_out, 1'b0);
         checkOutput("rst_a_valid", a_valid, 1'b0);
         checkOutput("rst_a_done", a_done, 1'b0);
         rst_n_a = 1'b1;
         mdl_a = model_reset(64'h4E);
      end else begin
         rst_n_b = 1'b0;
         #2;
         checkOutput("rst_b_out", b_out, 1'b0);
         checkOutput("rst_b_valid", b_valid, 1'b0);
         checkOutput("rst_b_chg", b_chg, 1'b0);
         rst_n_b = 1'b1;
         mdl_b = model_reset(64'h6);
      end
   endtask

   // Scoreboard: compare every queued expectation one time unit after the edge
   always @(posedge clk) begin
      #1;
      while (sb_q.size() != 0) begin
         mon_e = sb_q.pop_front();
         if (mon_e.dut == 0) begin
            checkOutput("sb_a_out", a_out, mon_e.out);
            checkOutput("sb_a_valid", a_valid, mon_e.valid);
            checkOutput("sb_a_changed", a_chg, mon_e.chg);
            checkOutput("sb_a_cfg_done", a_done, mon_e.done);
         end else begin
            checkOutput("sb_b_out", b_out, mon_e.out);
            checkOutput("sb_b_valid", b_valid, mon_e.valid);
            checkOutput("sb_b_changed", b_chg, mon_e.chg);
            checkOutput("sb_b_cfg_done", b_done, mon_e.done);
         end
      end
   end

   // Safety net so the run always ends
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenario sequence
   initial begin
      logic [7:0] pat;
      logic [1:0] row_v;
      rst_n_a = 1'b0; rst_n_b = 1'b0;
      a_in = 3'd0; a_en = 1'b0; a_bit = 1'b0;
      b_in = 2'd0; b_en = 1'b0; b_bit = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      checkOutput("init_out", a_out, 1'b0);
      checkOutput("init_valid", a_valid, 1'b0);
      checkOutput("init_changed", a_chg, 1'b0);
      checkOutput("init_cfg_done", a_done, 1'b0);
      rst_n_a = 1'b1; rst_n_b = 1'b1;
      mdl_a = model_reset(64'h4E);
      mdl_b = model_reset(64'h6);

      $display("[TB] reset evaluation");
      for (int i = 1; i <= 4; i++) begin
         stepA(3'd0, 1'b0, 1'b0);
         if (i < 4) checkOutput("rst_eval_wait", a_valid, 1'b0);
      end
      checkOutput("rst_eval_valid", a_valid, 1'b1);
      checkOutput("rst_eval_out", a_out, 1'b0);
      checkOutput("rst_eval_chg", a_chg, 1'b0);

      $display("[TB] single input change");
      stepA(3'd1, 1'b0, 1'b0);
      checkOutput("chg_drop_valid", a_valid, 1'b0);
      for (int i = 0; i < 3; i++) stepA(3'd1, 1'b0, 1'b0);
      checkOutput("chg_wait_valid", a_valid, 1'b0);
      stepA(3'd1, 1'b0, 1'b0);
      checkOutput("chg_eval_out", a_out, 1'b1);
      checkOutput("chg_eval_valid", a_valid, 1'b1);
      checkOutput("chg_pulse_hi", a_chg, 1'b1);
      stepA(3'd1, 1'b0, 1'b0);
      checkOutput("chg_pulse_lo", a_chg, 1'b0);

      $display("[TB] glitch rejection");
      for (int i = 0; i < 2; i++) begin
         stepA(3'd3, 1'b0, 1'b0);
         checkOutput("glitch_out", a_out, 1'b1);
         checkOutput("glitch_valid", a_valid, 1'b0);
      end
      for (int i = 0; i < 4; i++) begin
         stepA(3'd1, 1'b0, 1'b0);
         checkOutput("glitch_hold_out", a_out, 1'b1);
         checkOutput("glitch_hold_valid", a_valid, 1'b0);
         checkOutput("glitch_hold_chg", a_chg, 1'b0);
      end
      stepA(3'd1, 1'b0, 1'b0);
      checkOutput("glitch_back_valid", a_valid, 1'b1);
      checkOutput("glitch_back_out", a_out, 1'b1);
      checkOutput("glitch_back_chg", a_chg, 1'b0);

      $display("[TB] table reload");
      for (int i = 0; i < 5; i++) stepA(3'd7, 1'b0, 1'b0);
      checkOutput("reload_pre_out", a_out, 1'b0);
      checkOutput("reload_pre_valid", a_valid, 1'b1);
      for (int i = 0; i < 8; i++) begin
         stepA(3'd7, 1'b1, 1'b1);
         if (i < 7) checkOutput("reload_no_done", a_done, 1'b0);
      end
      checkOutput("reload_done", a_done, 1'b1);
      checkOutput("reload_drop_valid", a_valid, 1'b0);
      stepA(3'd7, 1'b0, 1'b0);
      checkOutput("reload_done_lo", a_done, 1'b0);
      checkOutput("reload_wait_valid", a_valid, 1'b0);
      for (int i = 0; i < 2; i++) stepA(3'd7, 1'b0, 1'b0);
      checkOutput("reload_wait_valid2", a_valid, 1'b0);
      stepA(3'd7, 1'b0, 1'b0);
      checkOutput("reload_eval_out", a_out, 1'b1);
      checkOutput("reload_eval_valid", a_valid, 1'b1);
      checkOutput("reload_eval_chg", a_chg, 1'b1);

      $display("[TB] aborted load");
      pulseReset(0);
      for (int i = 0; i < 5; i++) stepA(3'd7, 1'b0, 1'b0);
      checkOutput("abort_pre_out", a_out, 1'b0);
      checkOutput("abort_pre_valid", a_valid, 1'b1);
      for (int i = 0; i < 5; i++) begin
         stepA(3'd7, 1'b1, 1'b1);
         checkOutput("abort_no_done", a_done, 1'b0);
      end
      stepA(3'd7, 1'b0, 1'b0);
      checkOutput("abort_drop_done", a_done, 1'b0);
      for (int i = 0; i < 3; i++) begin
         stepA(3'd7, 1'b1, 1'b0);
         checkOutput("abort_restart_done", a_done, 1'b0);
      end
      stepA(3'd7, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) stepA(3'd6, 1'b0, 1'b0);
      checkOutput("abort_row6_out", a_out, 1'b1);
      checkOutput("abort_row6_valid", a_valid, 1'b1);
      for (int i = 0; i < 5; i++) stepA(3'd7, 1'b0, 1'b0);
      checkOutput("abort_row7_out", a_out, 1'b0);
      checkOutput("abort_row7_chg", a_chg, 1'b1);

      $display("[TB] commit on evaluation edge");
      pat = 8'h96;
      for (int i = 0; i < 8; i++) begin
         stepA((i < 3) ? 3'd7 : 3'd6, 1'b1, pat[7-i]);
         if (i < 7) checkOutput("sim_no_done", a_done, 1'b0);
      end
      checkOutput("sim_done", a_done, 1'b1);
      checkOutput("sim_no_eval_valid", a_valid, 1'b0);
      checkOutput("sim_no_eval_chg", a_chg, 1'b0);
      for (int i = 0; i < 3; i++) stepA(3'd6, 1'b0, 1'b0);
      checkOutput("sim_wait_valid", a_valid, 1'b0);
      stepA(3'd6, 1'b0, 1'b0);
      checkOutput("sim_eval_out", a_out, 1'b1);
      checkOutput("sim_eval_chg", a_chg, 1'b1);

      $display("[TB] input change on evaluation edge");
      for (int i = 0; i < 4; i++) stepA(3'd7, 1'b0, 1'b0);
      checkOutput("race_wait_valid", a_valid, 1'b0);
      stepA(3'd6, 1'b0, 1'b0);
      checkOutput("race_no_eval_valid", a_valid, 1'b0);
      checkOutput("race_no_eval_out", a_out, 1'b1);
      for (int i = 0; i < 3; i++) stepA(3'd6, 1'b0, 1'b0);
      stepA(3'd6, 1'b0, 1'b0);
      checkOutput("race_eval_valid", a_valid, 1'b1);
      checkOutput("race_eval_out", a_out, 1'b1);
      checkOutput("race_eval_chg", a_chg, 1'b0);

      $display("[TB] second configuration (XOR)");
      checkOutput("xor_idle_valid", b_valid, 1'b1);
      checkOutput("xor_idle_out", b_out, 1'b0);
      for (int r = 0; r < 4; r++) begin
         row_v = 2'(r + 1);
         for (int k = 0; k < 5; k++) stepB(row_v, 1'b0, 1'b0);
         checkOutput("xor_row_out", b_out, row_v[1] ^ row_v[0]);
         checkOutput("xor_row_valid", b_valid, 1'b1);
      end
      for (int i = 0; i < 4; i++) begin
         stepB(2'd3, 1'b1, 1'b1);
         if (i < 3) checkOutput("xor_load_no_done", b_done, 1'b0);
      end
      checkOutput("xor_load_done", b_done, 1'b1);
      for (int i = 0; i < 4; i++) stepB(2'd3, 1'b0, 1'b0);
      checkOutput("xor_newtt_out", b_out, 1'b1);
      checkOutput("xor_newtt_valid", b_valid, 1'b1);
      for (int i = 0; i < 2; i++) stepB(2'd3, 1'b1, 1'b0);
      pulseReset(1);
      for (int i = 0; i < 5; i++) stepB(2'd3, 1'b0, 1'b0);
      checkOutput("xor_restore_out", b_out, 1'b0);
      checkOutput("xor_restore_valid", b_valid, 1'b1);

      checkOutput("sb_drained", sb_q.size() == 0, 1'b1);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
